// File: rtl/cfg_uart_pkg.sv
// ============================================================================
//  Module      : cfg_uart_pkg
//  Description : Shared widths, rx/tx state encoding and response codes for
//                the config-channel UART responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cfg_uart_pkg;

    localparam int BYTE_W    = 8;
    localparam int CMD_BYTES = 3;
    localparam int RSP_BYTES = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } uart_st_e;

    localparam logic [15:0] ACK = 16'h0A5A;
    localparam logic [15:0] NAK = 16'h05A5;

endpackage

`default_nettype wire

// File: rtl/cfg_uart_rx_byte.sv
// ============================================================================
//  Module      : cfg_uart_rx_byte
//  Description : RX synchroniser, baud counter and byte FSM (8N1, or 8E1 with
//                CFG_PARITY_EN defined).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_uart_rx_byte
    import cfg_uart_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_i,
    output logic [BYTE_W-1:0] byte_o,
    output logic              byte_vld_o,
    output logic              byte_err_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] c_HALF = CNT_W'(BAUD_DIV / 2);
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(BAUD_DIV - 1);

    logic              rx_s1_q, rx_s2_q, rx_prev_q;
    uart_st_e          st_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        bit_q;
    logic [BYTE_W-1:0] shr_q;
    logic              brk_q;
    logic              w_tick;
    logic              w_par_bad;

    assign w_tick = (cnt_q == '0);
    assign byte_o = shr_q;
    assign busy_o = (st_q != IDLE);

`ifdef CFG_PARITY_EN
    logic par_err_q;
    assign w_par_bad = par_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else if (st_q == PAR && w_tick) begin
            par_err_q <= rx_s2_q ^ (^shr_q);
        end
    end
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            st_q       <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shr_q      <= '0;
            brk_q      <= 1'b0;
            byte_vld_o <= 1'b0;
            byte_err_o <= 1'b0;
        end else begin
            rx_s1_q    <= rx_i;
            rx_s2_q    <= rx_s1_q;
            rx_prev_q  <= rx_s2_q;
            byte_vld_o <= 1'b0;
            byte_err_o <= 1'b0;
            if (st_q != IDLE && !w_tick) begin
                cnt_q <= cnt_q - 1'b1;
            end
            case (st_q)
                IDLE: begin
                    if (rx_prev_q && !rx_s2_q) begin
                        cnt_q <= c_HALF;
                        st_q  <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (!rx_s2_q) begin
                            cnt_q <= c_FULL;
                            bit_q <= '0;
                            st_q  <= DATA;
                        end else begin
                            st_q  <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        shr_q <= {rx_s2_q, shr_q[BYTE_W-1:1]};
                        cnt_q <= c_FULL;
                        bit_q <= bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
`ifdef CFG_PARITY_EN
                            st_q <= PAR;
`else
                            st_q <= STOP;
`endif
                        end
                    end
                end
`ifdef CFG_PARITY_EN
                PAR: begin
                    if (w_tick) begin
                        cnt_q <= c_FULL;
                        st_q  <= STOP;
                    end
                end
`endif
                STOP: begin
                    // After a bad byte, hold here until the line is released.
                    if (brk_q) begin
                        if (rx_s2_q) begin
                            brk_q <= 1'b0;
                            st_q  <= IDLE;
                        end
                    end else if (w_tick) begin
                        if (rx_s2_q && !w_par_bad) begin
                            byte_vld_o <= 1'b1;
                            st_q       <= IDLE;
                        end else begin
                            byte_err_o <= 1'b1;
                            brk_q      <= 1'b1;
                        end
                    end
                end
                default: st_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/cfg_uart_slv.sv
// ============================================================================
//  Module      : cfg_uart_slv
//  Description : Config-channel UART responder: 3-byte command RX, 2-byte
//                response TX. Optional even parity via CFG_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cfg_uart_slv
    import cfg_uart_pkg::*;
#(
    parameter int BAUD_DIV = 2604,
    parameter int FRM_TMO  = 65535
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        RX_C,
    output logic                        TX_C,
    output logic [CMD_BYTES*BYTE_W-1:0] cmd_data,
    output logic                        cmd_rdy,
    input  logic [RSP_BYTES*BYTE_W-1:0] resp,
    input  logic                        snd_resp,
    output logic                        tx_busy,
    output logic                        resp_sent,
    output logic                        frm_err
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int TMO_W = $clog2(FRM_TMO + 1);
    localparam logic [CNT_W-1:0] c_FULL    = CNT_W'(BAUD_DIV - 1);
    localparam logic [TMO_W-1:0] c_TMO_END = TMO_W'(FRM_TMO - 1);
    localparam logic [1:0]       c_LAST    = 2'(CMD_BYTES - 1);

    logic [BYTE_W-1:0]   w_rx_byte;
    logic                w_rx_vld, w_rx_err, w_rx_busy;
    logic [1:0]          byte_idx_q;
    logic [2*BYTE_W-1:0] hold_q;
    logic [TMO_W-1:0]    tmo_q;

    cfg_uart_rx_byte #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx_i      (RX_C),
        .byte_o    (w_rx_byte),
        .byte_vld_o(w_rx_vld),
        .byte_err_o(w_rx_err),
        .busy_o    (w_rx_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx_q <= '0;
            hold_q     <= '0;
            tmo_q      <= '0;
            cmd_data   <= '0;
            cmd_rdy    <= 1'b0;
            frm_err    <= 1'b0;
        end else begin
            cmd_rdy <= 1'b0;
            frm_err <= w_rx_err;
            if (w_rx_err) begin
                byte_idx_q <= '0;
            end else if (w_rx_vld) begin
                if (byte_idx_q == c_LAST) begin
                    cmd_data   <= {hold_q, w_rx_byte};
                    cmd_rdy    <= 1'b1;
                    byte_idx_q <= '0;
                end else begin
                    hold_q     <= {hold_q[BYTE_W-1:0], w_rx_byte};
                    byte_idx_q <= byte_idx_q + 1'b1;
                end
            end else if (tmo_q == c_TMO_END) begin
                byte_idx_q <= '0;
            end
            // Idle time only accumulates while a partial frame is pending.
            tmo_q <= (byte_idx_q == '0 || w_rx_busy) ? '0 : tmo_q + 1'b1;
        end
    end

    uart_st_e          tx_st_q;
    logic [CNT_W-1:0]  tx_cnt_q;
    logic [2:0]        tx_bit_q;
    logic              tx_idx_q;
    logic [BYTE_W-1:0] tx_shr_q, tx_lo_q;
    logic              w_tx_tick;

    assign w_tx_tick = (tx_cnt_q == '0);

`ifdef CFG_PARITY_EN
    logic tx_par_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_par_q <= 1'b0;
        end else if (tx_st_q == START && w_tx_tick) begin
            tx_par_q <= tx_shr_q[0];
        end else if (tx_st_q == DATA && w_tx_tick && tx_bit_q != 3'd7) begin
            tx_par_q <= tx_par_q ^ tx_shr_q[0];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_st_q   <= IDLE;
            tx_cnt_q  <= '0;
            tx_bit_q  <= '0;
            tx_idx_q  <= 1'b0;
            tx_shr_q  <= '0;
            tx_lo_q   <= '0;
            TX_C      <= 1'b1;
            tx_busy   <= 1'b0;
            resp_sent <= 1'b0;
        end else begin
            resp_sent <= 1'b0;
            if (tx_st_q != IDLE && !w_tx_tick) begin
                tx_cnt_q <= tx_cnt_q - 1'b1;
            end
            case (tx_st_q)
                IDLE: begin
                    if (snd_resp) begin
                        tx_shr_q <= resp[2*BYTE_W-1:BYTE_W];
                        tx_lo_q  <= resp[BYTE_W-1:0];
                        tx_idx_q <= 1'b0;
                        tx_cnt_q <= c_FULL;
                        TX_C     <= 1'b0;
                        tx_busy  <= 1'b1;
                        tx_st_q  <= START;
                    end
                end
                START: begin
                    if (w_tx_tick) begin
                        TX_C     <= tx_shr_q[0];
                        tx_shr_q <= tx_shr_q >> 1;
                        tx_bit_q <= '0;
                        tx_cnt_q <= c_FULL;
                        tx_st_q  <= DATA;
                    end
                end
                DATA: begin
                    if (w_tx_tick) begin
                        tx_cnt_q <= c_FULL;
                        if (tx_bit_q == 3'd7) begin
`ifdef CFG_PARITY_EN
                            TX_C    <= tx_par_q;
                            tx_st_q <= PAR;
`else
                            TX_C    <= 1'b1;
                            tx_st_q <= STOP;
`endif
                        end else begin
                            TX_C     <= tx_shr_q[0];
                            tx_shr_q <= tx_shr_q >> 1;
                            tx_bit_q <= tx_bit_q + 1'b1;
                        end
                    end
                end
`ifdef CFG_PARITY_EN
                PAR: begin
                    if (w_tx_tick) begin
                        TX_C     <= 1'b1;
                        tx_cnt_q <= c_FULL;
                        tx_st_q  <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_tx_tick) begin
                        if (!tx_idx_q) begin
                            tx_idx_q <= 1'b1;
                            tx_shr_q <= tx_lo_q;
                            TX_C     <= 1'b0;
                            tx_cnt_q <= c_FULL;
                            tx_st_q  <= START;
                        end else begin
                            TX_C      <= 1'b1;
                            tx_busy   <= 1'b0;
                            resp_sent <= 1'b1;
                            tx_st_q   <= IDLE;
                        end
                    end
                end
                default: tx_st_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_cfg_uart_slv.sv
// ============================================================================
//  Module      : tb_cfg_uart_slv
//  Description : Self-checking bench for cfg_uart_slv with a byte-level
//                reference model and a serial decoder on TX_C.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cfg_uart_slv;

    localparam int BAUD = 16;
    localparam int TMO  = 1000;
`ifdef CFG_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif

    logic        clk = 1'b0, rst = 1'b1, RX_C = 1'b1, snd_resp = 1'b0;
    logic [15:0] resp = '0;
    logic        TX_C, cmd_rdy, tx_busy, resp_sent, frm_err;
    logic [23:0] cmd_data;

    cfg_uart_slv #(.BAUD_DIV(BAUD), .FRM_TMO(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .RX_C     (RX_C),
        .TX_C     (TX_C),
        .cmd_data (cmd_data),
        .cmd_rdy  (cmd_rdy),
        .resp     (resp),
        .snd_resp (snd_resp),
        .tx_busy  (tx_busy),
        .resp_sent(resp_sent),
        .frm_err  (frm_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int n_rdy = 0, n_err = 0, n_sent = 0, n_busy = 0;

    always @(negedge clk) begin
        if (cmd_rdy)   n_rdy++;
        if (frm_err)   n_err++;
        if (resp_sent) n_sent++;
        if (tx_busy)   n_busy++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: frame = last three good bytes with no error or timeout between.
    logic [7:0]  m_bytes[$];
    logic [23:0] m_cmd = '0;
    int          m_rdy = 0, m_err = 0;

    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            m_err++;
            m_bytes.delete();
        end else begin
            m_bytes.push_back(b);
            if (m_bytes.size() == 3) begin
                m_cmd = {m_bytes[0], m_bytes[1], m_bytes[2]};
                m_rdy++;
                m_bytes.delete();
            end
        end
    endtask

    task automatic idle(input int n);
        RX_C = 1'b1;
        repeat (n) @(negedge clk);
        if (n >= TMO) m_bytes.delete();
    endtask

    task automatic drive_bit(input logic v);
        RX_C = v;
        repeat (BAUD) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef CFG_PARITY_EN
        drive_bit((^b) ^ !par_ok);
`endif
        drive_bit(stop_ok);
        RX_C = 1'b1;
        if (!stop_ok) repeat (2 * BAUD) @(negedge clk);
        model_byte(b, stop_ok && par_ok);
    endtask

    task automatic send_frame(input logic [23:0] f);
        for (int i = 2; i >= 0; i--) begin
            send_byte(f[i*8 +: 8], 1'b1, 1'b1);
            idle(int'($urandom_range(0, 20)));
        end
    endtask

    task automatic chk_rx(input string tag);
        repeat (4) @(negedge clk);
        check({tag, "_cmd_data"}, 32'(cmd_data), 32'(m_cmd));
        check({tag, "_rdy_cnt"}, 32'(n_rdy), 32'(m_rdy));
        check({tag, "_err_cnt"}, 32'(n_err), 32'(m_err));
    endtask

    // Serial decoder on TX_C: centre-samples each bit at the nominal bit period.
    logic [7:0] txq[$];
    bit         txstop[$];
    initial begin
        logic [7:0] b;
        logic       p;
        forever begin
            @(negedge TX_C);
            repeat (BAUD / 2) @(posedge clk);
            #1;
            if (TX_C == 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(posedge clk);
                    #1 b[i] = TX_C;
                end
                p = ^b;
`ifdef CFG_PARITY_EN
                repeat (BAUD) @(posedge clk);
                #1 p = TX_C;
`endif
                repeat (BAUD) @(posedge clk);
                #1;
                txq.push_back(b);
                txstop.push_back(TX_C && (p == ^b));
            end
        end
    end

    task automatic send_resp(input logic [15:0] w);
        int s0 = n_sent;
        int b0 = n_busy;
        int k  = 0;
        resp     = w;
        snd_resp = 1'b1;
        @(negedge clk);
        snd_resp = 1'b0;
        resp     = 16'($urandom);
        while (n_sent == s0 && k < 2 * BITS * BAUD + 50) begin
            @(negedge clk);
            k++;
        end
        check("resp_sent_cnt", 32'(n_sent - s0), 32'd1);
        check("tx_busy_len", 32'(n_busy - b0), 32'(2 * BITS * BAUD));
        check("tx_byte_cnt", 32'(txq.size()), 32'd2);
        if (txq.size() == 2) begin
            check("tx_byte0", 32'(txq.pop_front()), 32'(w[15:8]));
            check("tx_byte1", 32'(txq.pop_front()), 32'(w[7:0]));
            check("tx_stop0", 32'(txstop.pop_front()), 32'd1);
            check("tx_stop1", 32'(txstop.pop_front()), 32'd1);
        end
        txq.delete();
        txstop.delete();
    endtask

    initial begin
        logic [23:0] f;
        logic [15:0] w;
        int          s0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx_c", 32'(TX_C), 32'd1);
        check("rst_cmd_data", 32'(cmd_data), 32'd0);
        check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("rst_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_resp_sent", 32'(resp_sent), 32'd0);
        check("rst_frm_err", 32'(frm_err), 32'd0);

        send_frame(24'h3A5B12);
        chk_rx("frame");

        send_resp(16'h0A5A);
        send_resp(16'h05A5);

        send_byte(8'h3A, 1'b0, 1'b1);
        send_frame(24'h112233);
        chk_rx("bad_stop");

        send_byte(8'h55, 1'b1, 1'b1);
        send_byte(8'hAA, 1'b1, 1'b1);
        idle(1200);
        send_frame(24'hC0FFEE);
        chk_rx("timeout");

        RX_C = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        chk_rx("glitch");
        send_frame(24'h000001);
        chk_rx("after_glitch");

        for (int i = 0; i < 6; i++) begin
            f = 24'($urandom);
            w = 16'($urandom);
            fork
                send_frame(f);
                send_resp(w);
            join
            chk_rx("duplex");
        end

`ifdef CFG_PARITY_EN
        send_byte(8'h5C, 1'b1, 1'b1);
        send_byte(8'h66, 1'b1, 1'b0);
        send_frame(24'hABCDEF);
        chk_rx("parity");
`endif

        // Reset partway through the second response byte.
        w  = 16'($urandom);
        s0 = n_sent;
        resp     = w;
        snd_resp = 1'b1;
        @(negedge clk);
        snd_resp = 1'b0;
        repeat (BITS * BAUD + BITS * BAUD / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_tx_c", 32'(TX_C), 32'd1);
        check("abort_tx_busy", 32'(tx_busy), 32'd0);
        check("abort_cmd_data", 32'(cmd_data), 32'd0);
        m_bytes.delete();
        m_cmd = '0;
        repeat (2 * BITS * BAUD) @(negedge clk);
        check("abort_no_sent", 32'(n_sent - s0), 32'd0);
        check("abort_byte0", 32'(txq.size() > 0 ? txq[0] : 8'h00), 32'(w[15:8]));
        txq.delete();
        txstop.delete();

        send_resp(16'h0A5A);
        send_frame(24'($urandom));
        chk_rx("post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
